id_stage: RTL and testbench

Decode stage of the five-stage RV32I pipeline. Consumes the IF/ID pipeline register contents, reads the register file, decodes immediates and control selects, and owns the ID/EX pipeline register (`id_ex_stage_reg_t`). Also detects load-use hazards against the instruction currently held in ID/EX. On a hazard it stalls fetch and inserts a bubble.

---
 rtl/id_stage.sv | 162 ++++++++++++++++
 tb/tb_id_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I decode stage: regfile read, immediate/control decode, load-use hazard detection, ID/EX register.
// Latency 1 cycle; holds on ex_stall, inserts a bubble and raises id_stall on load-use, flush kills ID/EX.
package id_stage_pkg;

   typedef enum logic {
      rs1_out = 1'b0,
      pc_out  = 1'b1
   } alu_m1_sel_t;

   typedef enum logic {
      rs2_out = 1'b0,
      imm_out = 1'b1
   } alu_m2_sel_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [63:0] order;
      logic [4:0]  rd_s;
      logic [4:0]  rs1_s;
      logic [4:0]  rs2_s;
      logic [31:0] rs1_v;
      logic [31:0] rs2_v;
      logic [31:0] imm;
      alu_m1_sel_t alu_m1_sel;
      alu_m2_sel_t alu_m2_sel;
      logic        regf_we;
      logic        mem_read;
      logic        mem_write;
      logic        illegal;
   } id_ex_stage_reg_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

module id_stage
   import id_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [31:0]      if_inst,
   input  logic [31:0]      if_pc,
   input  logic [63:0]      if_order,
   output logic [4:0]       rs1_s,
   output logic [4:0]       rs2_s,
   input  logic [31:0]      rs1_v,
   input  logic [31:0]      rs2_v,
   input  logic             ex_stall,
   input  logic             flush,
   output logic             id_stall,
   output id_ex_stage_reg_t id_ex
);

   logic [6:0]       opcode;
   logic [4:0]       rd;
   logic             uses_rs1;
   logic             uses_rs2;
   logic             hazard;
   id_ex_stage_reg_t dec;

   assign opcode = if_inst[6:0];
   assign rd     = if_inst[11:7];
   assign rs1_s  = if_inst[19:15];
   assign rs2_s  = if_inst[24:20];

   always_comb begin
      dec            = '0;
      dec.valid      = if_valid;
      dec.inst       = if_inst;
      dec.pc         = if_pc;
      dec.order      = if_order;
      dec.rd_s       = rd;
      dec.rs1_s      = rs1_s;
      dec.rs2_s      = rs2_s;
      dec.rs1_v      = rs1_v;
      dec.rs2_v      = rs2_v;
      dec.alu_m1_sel = rs1_out;
      dec.alu_m2_sel = imm_out;
      uses_rs1       = 1'b1;
      uses_rs2       = 1'b0;
      case (opcode)
         OPC_LUI: begin
            dec.imm     = {if_inst[31:12], 12'b0};
            dec.regf_we = 1'b1;
            uses_rs1    = 1'b0;
         end
         OPC_AUIPC: begin
            dec.imm        = {if_inst[31:12], 12'b0};
            dec.regf_we    = 1'b1;
            dec.alu_m1_sel = pc_out;
            uses_rs1       = 1'b0;
         end
         OPC_JAL: begin
            dec.imm        = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                              if_inst[20], if_inst[30:21], 1'b0};
            dec.regf_we    = 1'b1;
            dec.alu_m1_sel = pc_out;
            uses_rs1       = 1'b0;
         end
         OPC_JALR, OPC_OP_IMM: begin
            dec.imm     = {{20{if_inst[31]}}, if_inst[31:20]};
            dec.regf_we = 1'b1;
         end
         OPC_LOAD: begin
            dec.imm      = {{20{if_inst[31]}}, if_inst[31:20]};
            dec.regf_we  = 1'b1;
            dec.mem_read = 1'b1;
         end
         OPC_STORE: begin
            dec.imm       = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
            dec.mem_write = 1'b1;
            uses_rs2      = 1'b1;
         end
         OPC_BRANCH: begin
            dec.imm        = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                              if_inst[30:25], if_inst[11:8], 1'b0};
            dec.alu_m1_sel = pc_out;
            dec.alu_m2_sel = rs2_out;
            uses_rs2       = 1'b1;
         end
         OPC_OP: begin
            dec.regf_we    = 1'b1;
            dec.alu_m2_sel = rs2_out;
            uses_rs2       = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      // x0 is never a real destination
      if (rd == 5'd0) dec.regf_we = 1'b0;
   end

   // Compares only register indices, so read data never reaches id_stall
   assign hazard = if_valid & id_ex.valid & id_ex.mem_read & (id_ex.rd_s != 5'd0) &
                   ((uses_rs1 & (rs1_s == id_ex.rd_s)) | (uses_rs2 & (rs2_s == id_ex.rd_s)));

   assign id_stall = !flush & (ex_stall | hazard);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         id_ex <= '0;
      else if (flush)
         id_ex <= '0;
      else if (ex_stall)
         id_ex <= id_ex;
      else if (hazard)
         id_ex <= '0;
      else
         id_ex <= dec;
   end

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage with hand-computed expectations.
module tb_id_stage;
   import id_stage_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             if_valid = 1'b0;
   logic [31:0]      if_inst = '0;
   logic [31:0]      if_pc = '0;
   logic [63:0]      if_order = '0;
   logic [4:0]       rs1_s;
   logic [4:0]       rs2_s;
   logic [31:0]      rs1_v = '0;
   logic [31:0]      rs2_v = '0;
   logic             ex_stall = 1'b0;
   logic             flush = 1'b0;
   logic             id_stall;
   id_ex_stage_reg_t id_ex;

   int checks = 0;
   int errors = 0;

   id_stage dut (
      .clk      (clk),
      .rst      (rst),
      .if_valid (if_valid),
      .if_inst  (if_inst),
      .if_pc    (if_pc),
      .if_order (if_order),
      .rs1_s    (rs1_s),
      .rs2_s    (rs2_s),
      .rs1_v    (rs1_v),
      .rs2_v    (rs2_v),
      .ex_stall (ex_stall),
      .flush    (flush),
      .id_stall (id_stall),
      .id_ex    (id_ex)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [63:0] ord);
      if_valid = v;
      if_inst  = inst;
      if_pc    = pc;
      if_order = ord;
   endtask

   initial begin
      // reset state
      step();
      chk("rst_valid", id_ex.valid, 0);
      chk("rst_stall", id_stall, 0);
      chk("rst_all", id_ex, 0);
      rst = 1'b0;

      // ADDI x1,x0,5
      drive(1, 32'h0050_0093, 32'h1ece_b000, 64'd7);
      rs1_v = 32'h1111_0000;
      #1;
      chk("addi_rs1s", rs1_s, 0);
      chk("addi_rs2s", rs2_s, 5);
      chk("addi_stall", id_stall, 0);
      step();
      chk("addi_valid", id_ex.valid, 1);
      chk("addi_rd", id_ex.rd_s, 1);
      chk("addi_imm", id_ex.imm, 5);
      chk("addi_we", id_ex.regf_we, 1);
      chk("addi_m1", id_ex.alu_m1_sel, rs1_out);
      chk("addi_m2", id_ex.alu_m2_sel, imm_out);
      chk("addi_order", id_ex.order, 7);
      chk("addi_pc", id_ex.pc, 32'h1ece_b000);
      chk("addi_rs1v", id_ex.rs1_v, 32'h1111_0000);
      chk("addi_ill", id_ex.illegal, 0);

      // load-use: LW x2,0(x1) then ADD x3,x2,x1
      drive(1, 32'h0000_a103, 32'h1ece_b004, 64'd8);
      step();
      chk("lw_rd", id_ex.rd_s, 2);
      chk("lw_mrd", id_ex.mem_read, 1);
      chk("lw_we", id_ex.regf_we, 1);
      drive(1, 32'h0011_01b3, 32'h1ece_b008, 64'd9);
      #1;
      chk("lu_stall", id_stall, 1);
      chk("lu_rs1s", rs1_s, 2);
      step();
      chk("lu_bubble", id_ex.valid, 0);
      chk("lu_bubble_inst", id_ex.inst, 0);
      chk("lu_stall_drop", id_stall, 0);
      step();
      chk("add_valid", id_ex.valid, 1);
      chk("add_inst", id_ex.inst, 32'h0011_01b3);
      chk("add_rs1s", id_ex.rs1_s, 2);
      chk("add_rs2s", id_ex.rs2_s, 1);
      chk("add_rd", id_ex.rd_s, 3);
      chk("add_m2", id_ex.alu_m2_sel, rs2_out);

      // LW x0,0(x1) then ADD x3,x0,x0 must not stall
      drive(1, 32'h0000_a003, 32'h1ece_b00c, 64'd10);
      step();
      chk("lw0_we", id_ex.regf_we, 0);
      drive(1, 32'h0000_01b3, 32'h1ece_b010, 64'd11);
      #1;
      chk("nofalse_stall", id_stall, 0);
      step();
      chk("nofalse_valid", id_ex.valid, 1);
      chk("nofalse_inst", id_ex.inst, 32'h0000_01b3);

      // ex_stall held 3 cycles
      drive(1, 32'h0050_0093, 32'h1ece_b014, 64'd12);
      ex_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("exs_stall", id_stall, 1);
         step();
         chk("exs_hold_inst", id_ex.inst, 32'h0000_01b3);
         chk("exs_hold_order", id_ex.order, 11);
      end
      flush = 1'b1;
      #1;
      chk("flush_stall", id_stall, 0);
      step();
      chk("flush_valid", id_ex.valid, 0);
      chk("flush_inst", id_ex.inst, 0);
      flush = 1'b0;
      ex_stall = 1'b0;

      // flush beats a load-use hazard
      drive(1, 32'h0000_a103, 32'h1ece_b018, 64'd13);
      step();
      drive(1, 32'h0011_01b3, 32'h1ece_b01c, 64'd14);
      flush = 1'b1;
      #1;
      chk("flhz_stall", id_stall, 0);
      step();
      chk("flhz_valid", id_ex.valid, 0);
      flush = 1'b0;

      // SW x1,-4(x2)
      drive(1, 32'hfe11_2e23, 32'h1ece_b020, 64'd15);
      step();
      chk("sw_imm", id_ex.imm, 32'hffff_fffc);
      chk("sw_mwr", id_ex.mem_write, 1);
      chk("sw_we", id_ex.regf_we, 0);
      chk("sw_rs1s", id_ex.rs1_s, 2);
      chk("sw_rs2s", id_ex.rs2_s, 1);

      // opcode 0x7f with rd=1
      drive(1, 32'h0000_00ff, 32'h1ece_b024, 64'd16);
      step();
      chk("ill_flag", id_ex.illegal, 1);
      chk("ill_we", id_ex.regf_we, 0);
      chk("ill_mrd", id_ex.mem_read, 0);
      chk("ill_mwr", id_ex.mem_write, 0);
      chk("ill_valid", id_ex.valid, 1);
      chk("ill_imm", id_ex.imm, 0);

      // LUI x5,0x12345
      drive(1, 32'h1234_52b7, 32'h1ece_b028, 64'd17);
      step();
      chk("lui_imm", id_ex.imm, 32'h1234_5000);
      chk("lui_we", id_ex.regf_we, 1);
      chk("lui_m1", id_ex.alu_m1_sel, rs1_out);

      // JAL x1,+8
      drive(1, 32'h0080_00ef, 32'h1ece_b02c, 64'd18);
      step();
      chk("jal_imm", id_ex.imm, 8);
      chk("jal_m1", id_ex.alu_m1_sel, pc_out);
      chk("jal_rd", id_ex.rd_s, 1);

      // bubble-free invalid slot
      drive(0, 32'h0050_0093, 32'h1ece_b030, 64'd19);
      step();
      chk("inv_valid", id_ex.valid, 0);

      // asynchronous reset mid-cycle
      drive(1, 32'h0050_0093, 32'h1ece_b034, 64'd20);
      step();
      chk("pre_rst_valid", id_ex.valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", id_ex.valid, 0);
      chk("arst_stall", id_stall, 0);
      chk("arst_all", id_ex, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
